// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared constants for the serial magnitude comparator
package cmp_pkg;

    localparam int CMP_WIDTH = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/cmp_bit_slice.sv
// rtl/cmp_bit_slice.sv - combinational one-bit magnitude comparator slice
module cmp_bit_slice (
    input  logic i1,
    input  logic i2,
    output logic lt,
    output logic eq,
    output logic gt
);

    // Plain truth table of a single bit pair
    always_comb begin
        lt = ~i1 & i2;
        gt = i1 & ~i2;
        eq = ~(i1 ^ i2);
    end

endmodule

// File: rtl/cmp_serial_ctrl.sv
// rtl/cmp_serial_ctrl.sv - MSB-first serial unsigned comparator with start/busy/done handshake
import cmp_pkg::*;

module cmp_serial_ctrl #(
    parameter int WIDTH = CMP_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] min_out
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_idx;
    logic             r_dec_lt;
    logic             r_dec_gt;
    logic             r_busy;
    logic             r_done;
    logic             r_lt;
    logic             r_eq;
    logic             r_gt;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic             w_bit_lt;
    logic             w_bit_eq;
    logic             w_bit_gt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // The single shared slice looks at the currently indexed bit pair
    cmp_bit_slice u_slice (
        .i1 (r_a[r_idx]),
        .i2 (r_b[r_idx]),
        .lt (w_bit_lt),
        .eq (w_bit_eq),
        .gt (w_bit_gt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: scan ends at the first differing bit or after bit 0
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_SCAN;
            S_SCAN:  if (!w_bit_eq || (r_idx == '0)) w_next_state = S_FIN;
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Handshake outputs are registered, so done lands in the cycle after FIN
    always_comb begin
        w_busy_nxt = (w_next_state == S_SCAN);
        w_done_nxt = (r_state == S_FIN);
    end

    // Operand capture, bit-index counter, scan decision and held results
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_dec_lt <= 1'b0;
            r_dec_gt <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lt     <= 1'b0;
            r_eq     <= 1'b0;
            r_gt     <= 1'b0;
            r_max    <= '0;
            r_min    <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= CNT_W'(WIDTH - 1);
                    end
                end
                S_SCAN: begin
                    if (w_bit_eq && (r_idx != '0)) begin
                        r_idx <= r_idx - CNT_W'(1);
                    end else begin
                        r_dec_lt <= w_bit_lt;
                        r_dec_gt <= w_bit_gt;
                    end
                end
                S_FIN: begin
                    r_lt  <= r_dec_lt;
                    r_gt  <= r_dec_gt;
                    r_eq  <= ~(r_dec_lt | r_dec_gt);
                    r_max <= r_dec_lt ? r_b : r_a;
                    r_min <= r_dec_lt ? r_a : r_b;
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign lt      = r_lt;
    assign eq      = r_eq;
    assign gt      = r_gt;
    assign max_out = r_max;
    assign min_out = r_min;

endmodule

// File: tb/tb_cmp_serial_ctrl.sv
// tb/tb_cmp_serial_ctrl.sv - directed vector bench for cmp_serial_ctrl
module tb_cmp_serial_ctrl;

    localparam int W = 6;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        logic         lt;
        logic         eq;
        logic         gt;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         lt;
    logic         eq;
    logic         gt;
    logic [W-1:0] max_out;
    logic [W-1:0] min_out;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int d0;

    logic [2:0]   m_flags;
    logic [W-1:0] m_max;
    logic [W-1:0] m_min;

    vec_t vt [8];

    cmp_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .lt      (lt),
        .eq      (eq),
        .gt      (gt),
        .max_out (max_out),
        .min_out (min_out)
    );

    always #5 clk = ~clk;

    // Count done pulses mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input int e_lat,
                          input logic e_lt, input logic e_eq, input logic e_gt,
                          input logic [W-1:0] e_max, input logic [W-1:0] e_min, input string nm);
        int lat;
        int bcnt;
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        chk({nm, "_done_low"}, 32'(done), 32'(0));
        chk({nm, "_flags_kept"}, 32'({lt, eq, gt}), 32'(m_flags));
        bcnt = busy ? 1 : 0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) bcnt++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
        chk({nm, "_busy"}, 32'(bcnt), 32'(e_lat - 1));
        chk({nm, "_flags"}, 32'({lt, eq, gt}), 32'({e_lt, e_eq, e_gt}));
        chk({nm, "_max"}, 32'(max_out), 32'(e_max));
        chk({nm, "_min"}, 32'(min_out), 32'(e_min));
        m_flags = {e_lt, e_eq, e_gt};
        m_max = e_max;
        m_min = e_min;
    endtask

    initial begin
        vt[0] = '{6'h20, 6'h1F, 2, 1'b0, 1'b0, 1'b1, 6'h20, 6'h1F};
        vt[1] = '{6'h2A, 6'h2B, 7, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h2A};
        vt[2] = '{6'h3F, 6'h3F, 7, 1'b0, 1'b1, 1'b0, 6'h3F, 6'h3F};
        vt[3] = '{6'h01, 6'h02, 6, 1'b1, 1'b0, 1'b0, 6'h02, 6'h01};
        vt[4] = '{6'h00, 6'h00, 7, 1'b0, 1'b1, 1'b0, 6'h00, 6'h00};
        vt[5] = '{6'h10, 6'h08, 3, 1'b0, 1'b0, 1'b1, 6'h10, 6'h08};
        vt[6] = '{6'h3F, 6'h00, 2, 1'b0, 1'b0, 1'b1, 6'h3F, 6'h00};
        vt[7] = '{6'h07, 6'h05, 6, 1'b0, 1'b0, 1'b1, 6'h07, 6'h05};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_flags", 32'({lt, eq, gt}), 32'(0));
        chk("rst_max", 32'(max_out), 32'(0));
        chk("rst_min", 32'(min_out), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        m_flags = 3'b000;
        m_max = '0;
        m_min = '0;

        // Back-to-back table, operands flipped mid-scan inside run_op
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].lat, vt[i].lt, vt[i].eq, vt[i].gt,
                   vt[i].mx, vt[i].mn, $sformatf("v%0d", i));
        end

        // Results hold through idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_flags", 32'({lt, eq, gt}), 32'(m_flags));
        chk("hold_max", 32'(max_out), 32'(m_max));
        chk("hold_min", 32'(min_out), 32'(m_min));
        chk("hold_done", 32'(done), 32'(0));

        // Start while busy is ignored
        d0 = done_cnt;
        @(negedge clk);
        a = 6'h01;
        b = 6'h02;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("busy3_busy", 32'(busy), 32'(1));
        a = 6'h3F;
        b = 6'h00;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("busy_ign_done_cnt", 32'(done_cnt - d0), 32'(1));
        chk("busy_ign_flags", 32'({lt, eq, gt}), 32'(3'b100));
        chk("busy_ign_max", 32'(max_out), 32'(6'h02));
        chk("busy_ign_min", 32'(min_out), 32'(6'h01));
        m_flags = 3'b100;
        m_max = 6'h02;
        m_min = 6'h01;
        run_op(6'h3F, 6'h00, 2, 1'b0, 1'b0, 1'b1, 6'h3F, 6'h00, "after_ign");

        // rst and start together: reset wins
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        a = 6'h3F;
        b = 6'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'(0));
        chk("rst_start_flags", 32'({lt, eq, gt}), 32'(0));
        @(posedge clk);
        #1;
        chk("rst_start_busy2", 32'(busy), 32'(0));
        m_flags = 3'b000;
        m_max = '0;
        m_min = '0;
        run_op(6'h20, 6'h1F, 2, 1'b0, 1'b0, 1'b1, 6'h20, 6'h1F, "rebuild");

        // Reset during scan aborts without done
        @(negedge clk);
        a = 6'h20;
        b = 6'h10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'(1));
        d0 = done_cnt;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_flags", 32'({lt, eq, gt}), 32'(0));
        chk("abort_max", 32'(max_out), 32'(0));
        chk("abort_min", 32'(min_out), 32'(0));
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'(0));
        chk("abort_idle_busy", 32'(busy), 32'(0));
        m_flags = 3'b000;
        m_max = '0;
        m_min = '0;
        run_op(6'h20, 6'h10, 2, 1'b0, 1'b0, 1'b1, 6'h20, 6'h10, "post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
